nios_ii_nios2_gen2_0_cpu_mult_combine: RTL
==========================================

NIOS_II_NIOS2_GEN2_0_CPU_MULT_COMBINE -- requirements
Module: nios_ii_nios2_gen2_0_cpu_mult_combine

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the destination-register tag carried alongside each product.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port M_mul_cell_p1, input, 32: partial product src1[15:0]*src2[15:0].
REQ-005 SHALL have port M_mul_cell_p2, input, 32: partial product src1[15:0]*src2[31:16].
REQ-006 SHALL have port M_mul_cell_p3, input, 32: partial product src1[31:16]*src2[15:0].
REQ-007 SHALL have port in_valid, input, 1: partial products and tag are valid this cycle.
REQ-008 SHALL have port in_tag, input, TAG_W: destination register of the multiply.
REQ-009 SHALL have port in_ready, output, 1: the block accepts the input this cycle.
REQ-010 SHALL have port flush, input, 1: kill all in-flight multiplies (pipeline flush on exception or branch).
REQ-011 SHALL have port out_valid, output, 1: out_result and out_tag are valid.
REQ-012 SHALL have port out_ready, input, 1: the writeback stage consumes the output this cycle.
REQ-013 SHALL have port out_result, output, 32: low 32 bits of src1*src2.
REQ-014 SHALL have port out_tag, output, TAG_W: tag of out_result.

Function
REQ-015 SHALL be a two-stage pipeline, S1 then S2, with one valid bit per stage; out_valid = S2 valid.
REQ-016 S1 SHALL capture p1 (32b), a 16-bit mid = p2[15:0] + p3[15:0] (mod 2^16, carry discarded), and in_tag.
REQ-017 S2 SHALL compute out_result = S1.p1 + {S1.mid, 16'h0000} (mod 2^32, carry discarded) and register it with the S1 tag.
REQ-018 p2[31:16] and p3[31:16] SHALL NOT affect any output.
REQ-019 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-020 S2 SHALL load from S1 when S1 is valid and (S2 is empty or S2 transfers out this cycle).
REQ-021 in_ready SHALL equal !S1_valid || S1-advances-to-S2 this cycle (combinational from out_ready; no skid buffer).
REQ-022 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high; throughput SHALL be 1 per cycle.
REQ-023 While out_valid && !out_ready, out_result and out_tag SHALL hold stable.
REQ-024 A stage whose valid bit is clear SHALL leave its data registers unchanged.
REQ-025 Simultaneous out transfer and S1 advance SHALL replace S2 contents in the same cycle without a bubble.
REQ-026 flush SHALL clear S1 and S2 valid bits at the next edge; an input presented in the flush cycle SHALL be discarded.
REQ-027 During flush, in_ready SHALL remain per REQ-021, and an output transfer occurring in the flush cycle SHALL still count as delivered.
REQ-028 No combinational path SHALL exist from in_valid to out_valid, out_result or out_tag.

Reset
REQ-029 reset SHALL take priority over flush and all transfers.
REQ-030 On reset: S1/S2 valid = 0; out_valid = 0; out_result = 32'h0; out_tag = 0; in_ready = 1 in the cycle after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight products; none SHALL appear on the output afterwards.

Verification
REQ-032 p1=32'h0000000F, p2=32'h0000000C, p3=32'h0000000A, tag=3, out_ready=1 -> two cycles later out_valid=1, out_result=32'h0016000F, out_tag=3.
REQ-033 p1=p2=p3=32'hFFFE0001 (from -1 * -1) -> out_result=32'h00000001 (both wrap rules exercised).
REQ-034 Back-to-back inputs on 4 consecutive cycles with tags 1..4, out_ready=1 -> outputs on 4 consecutive cycles, in order, with no bubbles.
REQ-035 out_ready=0 for 5 cycles with 3 inputs offered -> 2 inputs accepted, then in_ready=0 with the output held stable; on release, in-order drain and acceptance of the 3rd input.
REQ-036 flush asserted while S1 and S2 are both valid and in_valid=1 -> out_valid=0 the next cycle, and no flushed tag ever appears on the output.
REQ-037 reset pulsed while the pipe is full -> all outputs at reset values the next cycle; a new input afterwards completes with 2-cycle latency.

Source files
------------

// File: rtl/nios_ii_nios2_gen2_0_cpu_mult_combine.sv
// Purpose: combine three 16x16 partial products into the low 32 bits of a 32x32 multiply, carrying a dest tag.
// Latency: 2 cycles from input transfer to out_valid; full throughput of one result per cycle.
// Backpressure: valid/ready; in_ready is combinational from out_ready (no skid buffer); flush kills in-flight ops.
module nios_ii_nios2_gen2_0_cpu_mult_combine #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    // S1 holds the low partial product and the folded middle term
    logic             s1_vld;
    logic [31:0]      s1_p1;
    logic [15:0]      s1_mid;
    logic [TAG_W-1:0] s1_tag;

    // S2 holds the finished product presented to writeback
    logic             s2_vld;
    logic [31:0]      s2_result;
    logic [TAG_W-1:0] s2_tag;

    logic             out_xfer;
    logic             s1_adv;
    logic             in_xfer;
    logic [15:0]      mid_sum;
    logic [31:0]      result_sum;

    // Upper halves of p2/p3 land above bit 31 of the product and are dropped
    logic             unused_hi;
    assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

    // Handshake decode: S1 may advance whenever S2 is free or draining this cycle
    always_comb begin
        out_xfer   = s2_vld && out_ready;
        s1_adv     = s1_vld && (!s2_vld || out_xfer);
        in_ready   = !s1_vld || s1_adv;
        in_xfer    = in_valid && in_ready;
        mid_sum    = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
        result_sum = s1_p1 + {s1_mid, 16'h0000};
    end

    // Stage 1 register: flush drops the incoming op and anything already held
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_p1  <= 32'h0;
            s1_mid <= 16'h0;
            s1_tag <= '0;
        end else if (flush) begin
            s1_vld <= 1'b0;
        end else if (in_xfer) begin
            s1_vld <= 1'b1;
            s1_p1  <= M_mul_cell_p1;
            s1_mid <= mid_sum;
            s1_tag <= in_tag;
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    // Stage 2 register: reload from S1 replaces a draining result without a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld    <= 1'b0;
            s2_result <= 32'h0;
            s2_tag    <= '0;
        end else if (flush) begin
            s2_vld <= 1'b0;
        end else if (s1_adv) begin
            s2_vld    <= 1'b1;
            s2_result <= result_sum;
            s2_tag    <= s1_tag;
        end else if (out_xfer) begin
            s2_vld <= 1'b0;
        end
    end

    // Outputs come straight from S2 registers, so in_valid never reaches them combinationally
    always_comb begin
        out_valid  = s2_vld;
        out_result = s2_result;
        out_tag    = s2_tag;
    end

endmodule
